// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router ingress path.
// Tracks header decode, payload load, full-FIFO stall and parity phases, and
// drives the load strobes plus busy back-pressure toward the source.
module router_fsm #(
  parameter logic [1:0] INVALID_ADDR = 2'b11
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic [1:0] dest_addr
);

  typedef enum logic [2:0] {
    StDecodeAddress    = 3'd0,
    StLoadFirstData    = 3'd1,
    StLoadData         = 3'd2,
    StWaitTillEmpty    = 3'd3,
    StFifoFullState    = 3'd4,
    StLoadAfterFull    = 3'd5,
    StLoadParity       = 3'd6,
    StCheckParityError = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] dest_addr_q, dest_addr_d;
  logic [1:0] empty_sel_addr;
  logic       sel_empty;
  logic       sel_soft_reset;

  // Pick the empty flag of the port being decoded (header) or owned (packet body).
  always_comb begin
    empty_sel_addr = (state_q == StDecodeAddress) ? data_in : dest_addr_q;
    sel_empty      = 1'b0;
    if (empty_sel_addr != INVALID_ADDR) begin
      case (empty_sel_addr)
        2'd0:    sel_empty = fifo_empty_0;
        2'd1:    sel_empty = fifo_empty_1;
        2'd2:    sel_empty = fifo_empty_2;
        default: sel_empty = 1'b0;
      endcase
    end
  end

  // Only the timeout reset of the port owning the current packet matters.
  always_comb begin
    sel_soft_reset = 1'b0;
    if (dest_addr_q != INVALID_ADDR) begin
      case (dest_addr_q)
        2'd0:    sel_soft_reset = soft_reset_0;
        2'd1:    sel_soft_reset = soft_reset_1;
        2'd2:    sel_soft_reset = soft_reset_2;
        default: sel_soft_reset = 1'b0;
      endcase
    end
  end

  // State and destination registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StDecodeAddress;
      dest_addr_q <= INVALID_ADDR;
    end else begin
      state_q     <= state_d;
      dest_addr_q <= dest_addr_d;
    end
  end

  // Next-state logic; a soft reset of the owning port overrides everything.
  always_comb begin
    state_d     = state_q;
    dest_addr_d = dest_addr_q;
    case (state_q)
      StDecodeAddress: begin
        if (pkt_valid && (data_in != INVALID_ADDR)) begin
          dest_addr_d = data_in;
          state_d     = sel_empty ? StLoadFirstData : StWaitTillEmpty;
        end
      end
      StWaitTillEmpty: begin
        if (sel_empty) state_d = StLoadFirstData;
      end
      StLoadFirstData: state_d = StLoadData;
      StLoadData: begin
        if (fifo_full)       state_d = StFifoFullState;
        else if (!pkt_valid) state_d = StLoadParity;
      end
      StFifoFullState: begin
        if (!fifo_full) state_d = StLoadAfterFull;
      end
      StLoadAfterFull: begin
        if (parity_done)        state_d = StDecodeAddress;
        else if (low_pkt_valid) state_d = StLoadParity;
        else                    state_d = StLoadData;
      end
      StLoadParity:       state_d = StCheckParityError;
      StCheckParityError: state_d = fifo_full ? StFifoFullState : StDecodeAddress;
      default:            state_d = StDecodeAddress;
    endcase
    if ((state_q != StDecodeAddress) && sel_soft_reset) state_d = StDecodeAddress;
  end

  // Moore output decode.
  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    case (state_q)
      StDecodeAddress: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      StLoadFirstData: lfd_state = 1'b1;
      StLoadData: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      StWaitTillEmpty: ;
      StFifoFullState: full_state = 1'b1;
      StLoadAfterFull: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      StLoadParity:       write_enb_reg = 1'b1;
      StCheckParityError: rst_int_reg = 1'b1;
      default: ;
    endcase
  end

  assign dest_addr = dest_addr_q;

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios followed by random traffic,
// every cycle compared against a phase-level reference model.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg;
  logic [1:0] dest_addr;

  int tests = 0;
  int fails = 0;

  // Phase identifiers of the reference model.
  localparam int PDa  = 10;
  localparam int PLfd = 20;
  localparam int PLd  = 30;
  localparam int PWte = 40;
  localparam int PFfs = 50;
  localparam int PLaf = 60;
  localparam int PLp  = 70;
  localparam int PCpe = 80;

  int         m_phase;
  logic [1:0] m_dest;

  router_fsm dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .busy          (busy),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .dest_addr     (dest_addr)
  );

  always #5 clock = ~clock;

  // {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int} per phase.
  function automatic logic [7:0] exp_out(int ph);
    case (ph)
      PDa:     return 8'b0100_0000;
      PLfd:    return 8'b1010_0000;
      PLd:     return 8'b0001_0010;
      PWte:    return 8'b1000_0000;
      PFfs:    return 8'b1000_0100;
      PLaf:    return 8'b1000_1010;
      PLp:     return 8'b1000_0010;
      PCpe:    return 8'b1000_0001;
      default: return 8'bxxxx_xxxx;
    endcase
  endfunction

  function automatic logic empty_of(logic [1:0] a);
    case (a)
      2'd0:    return fifo_empty_0;
      2'd1:    return fifo_empty_1;
      2'd2:    return fifo_empty_2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic soft_of(logic [1:0] a);
    case (a)
      2'd0:    return soft_reset_0;
      2'd1:    return soft_reset_1;
      2'd2:    return soft_reset_2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_out(input string tag, input int ph, input logic [1:0] dst);
    logic [7:0] obs;
    obs = {busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
           rst_int_reg};
    tests++;
    assert (obs === exp_out(ph)) else begin
      fails++;
      $error("FAIL %s strobes observed=%b expected=%b", tag, obs, exp_out(ph));
    end
    tests++;
    assert (dest_addr === dst) else begin
      fails++;
      $error("FAIL %s dest_addr observed=%b expected=%b", tag, dest_addr, dst);
    end
  endtask

  // Advance one clock: model consumes the current inputs, then compare.
  task automatic cycle(input string tag);
    int         np;
    logic [1:0] nd;
    np = m_phase;
    nd = m_dest;
    if (!resetn) begin
      np = PDa;
      nd = 2'b11;
    end else begin
      case (m_phase)
        PDa: if (pkt_valid && data_in != 2'b11) begin
          nd = data_in;
          np = empty_of(data_in) ? PLfd : PWte;
        end
        PWte: if (empty_of(m_dest)) np = PLfd;
        PLfd: np = PLd;
        PLd:  np = fifo_full ? PFfs : (!pkt_valid ? PLp : PLd);
        PFfs: np = fifo_full ? PFfs : PLaf;
        PLaf: np = parity_done ? PDa : (low_pkt_valid ? PLp : PLd);
        PLp:  np = PCpe;
        PCpe: np = fifo_full ? PFfs : PDa;
        default: np = PDa;
      endcase
      if (m_phase != PDa && soft_of(m_dest)) np = PDa;
    end
    @(posedge clock);
    #1;
    m_phase = np;
    m_dest  = nd;
    check_out(tag, m_phase, m_dest);
  endtask

  // One clock plus a check against a hand-derived expected phase.
  task automatic step(input string tag, input int ph, input logic [1:0] dst);
    cycle(tag);
    check_out({tag, "_dir"}, ph, dst);
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'b00; parity_done = 1'b0;
    low_pkt_valid = 1'b0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b0; fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    m_phase = PDa;
    m_dest  = 2'b11;
    #12;
    check_out("reset", PDa, 2'b11);
    @(posedge clock); #1;
    resetn = 1'b1;

    // Header to port 1 with an empty FIFO, then short packet end.
    pkt_valid = 1'b1; data_in = 2'b01; fifo_empty_1 = 1'b1;
    step("hdr1_lfd", PLfd, 2'b01);
    step("hdr1_ld", PLd, 2'b01);
    pkt_valid = 1'b0;
    step("hdr1_lp", PLp, 2'b01);
    step("hdr1_cpe", PCpe, 2'b01);
    step("hdr1_da", PDa, 2'b01);

    // Five-byte packet to port 0.
    pkt_valid = 1'b1; data_in = 2'b00; fifo_empty_0 = 1'b1;
    step("p0_lfd", PLfd, 2'b00);
    step("p0_ld1", PLd, 2'b00);
    step("p0_ld2", PLd, 2'b00);
    step("p0_ld3", PLd, 2'b00);
    pkt_valid = 1'b0;
    step("p0_lp", PLp, 2'b00);
    step("p0_cpe", PCpe, 2'b00);
    step("p0_da", PDa, 2'b00);

    // Invalid header address is never accepted.
    pkt_valid = 1'b1; data_in = 2'b11;
    for (int i = 0; i < 4; i++) step("inv_hold", PDa, 2'b00);

    // Port 2 busy: wait until its FIFO drains.
    data_in = 2'b10; fifo_empty_2 = 1'b0;
    for (int i = 0; i < 6; i++) step("wte_hold", PWte, 2'b10);
    fifo_empty_2 = 1'b1;
    step("wte_lfd", PLfd, 2'b10);
    step("wte_ld", PLd, 2'b10);

    // Full stall, then pkt_valid dropped while full.
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) step("full_hold", PFfs, 2'b10);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    step("full_laf", PLaf, 2'b10);
    step("full_lp", PLp, 2'b10);
    step("full_cpe", PCpe, 2'b10);
    pkt_valid = 1'b0; low_pkt_valid = 1'b0;
    step("full_da", PDa, 2'b10);

    // Full stall ending with parity already captured.
    pkt_valid = 1'b1; data_in = 2'b00;
    step("pd_lfd", PLfd, 2'b00);
    step("pd_ld", PLd, 2'b00);
    fifo_full = 1'b1;
    step("pd_ffs", PFfs, 2'b00);
    fifo_full = 1'b0; parity_done = 1'b1;
    step("pd_laf", PLaf, 2'b00);
    step("pd_da", PDa, 2'b00);
    parity_done = 1'b0; pkt_valid = 1'b0;
    step("pd_idle", PDa, 2'b00);

    // Soft reset: only the owning port's timeout aborts the packet.
    pkt_valid = 1'b1; data_in = 2'b01;
    step("sr_lfd", PLfd, 2'b01);
    step("sr_ld", PLd, 2'b01);
    soft_reset_0 = 1'b1;
    step("sr_other", PLd, 2'b01);
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b1;
    step("sr_own", PDa, 2'b01);
    soft_reset_1 = 1'b0;
    step("sr_lfd2", PLfd, 2'b01);
    step("sr_ld2", PLd, 2'b01);

    // Asynchronous reset mid-payload.
    #2;
    resetn = 1'b0;
    #1;
    check_out("async_rst", PDa, 2'b11);
    m_phase = PDa;
    m_dest  = 2'b11;
    step("rst_hold", PDa, 2'b11);
    resetn = 1'b1;
    pkt_valid = 1'b0;
    step("rst_rel", PDa, 2'b11);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      parity_done   = ($urandom_range(0, 5) == 0);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty_0  = ($urandom_range(0, 2) != 0);
      fifo_empty_1  = ($urandom_range(0, 2) != 0);
      fifo_empty_2  = ($urandom_range(0, 2) != 0);
      soft_reset_0  = ($urandom_range(0, 15) == 0);
      soft_reset_1  = ($urandom_range(0, 15) == 0);
      soft_reset_2  = ($urandom_range(0, 15) == 0);
      resetn        = ($urandom_range(0, 63) != 0);
      #1;
      if (!resetn) begin
        // Asynchronous reset takes effect before the next edge.
        m_phase = PDa;
        m_dest  = 2'b11;
        check_out("rand_async", m_phase, m_dest);
      end
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Packet-sequencing controller for the 1x3 router ingress path. It watches the incoming byte stream (pkt_valid, header address bits) and FIFO status. It drives the load-control strobes: detect_add and write_enb_reg into the synchroniser, and lfd/ld/laf/full/rst_int strobes into the ingress register block. It also produces busy back-pressure toward the source. Per-port soft resets from the synchroniser (issued after 30 idle cycles on a valid, unread output) abort the current packet.

Parameters:
INVALID_ADDR, 2'b11, header address value treated as no-destination; the packet is never accepted.

Ports:
clock  input  1  system clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
pkt_valid  input  1  source asserts while header/payload bytes are presented; deasserts with the parity byte
data_in  input  2  header address bits (byte[1:0]), sampled only in DECODE_ADDRESS
parity_done  input  1  register block has captured the parity byte
low_pkt_valid  input  1  register block saw pkt_valid fall while the FIFO was full
fifo_full  input  1  OR of the three FIFO full flags (from synchroniser)
fifo_empty_0, fifo_empty_1, fifo_empty_2  input  1 each  per-port FIFO empty
soft_reset_0, soft_reset_1, soft_reset_2  input  1 each  per-port timeout resets
busy  output  1  source must hold the current byte
detect_add  output  1  header-capture strobe to synchroniser/register block
lfd_state  output  1  loading header byte
ld_state  output  1  loading payload
laf_state  output  1  loading held byte after full
full_state  output  1  stalled on full FIFO
write_enb_reg  output  1  FIFO write qualifier to synchroniser
rst_int_reg  output  1  clear internal parity-error state / check parity
dest_addr  output  2  latched destination of the current packet

Behaviour:
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, WAIT_TILL_EMPTY, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR. Single registered state plus registered dest_addr.
- Reset (resetn low, asynchronous): state=DECODE_ADDRESS, dest_addr=INVALID_ADDR. Outputs: detect_add=1, all other outputs 0.
- Selected empty flag: fifo_empty_<data_in> in DECODE_ADDRESS, fifo_empty_<dest_addr> elsewhere. A value of INVALID_ADDR selects 0 (not empty).
- Transitions:
  - DECODE_ADDRESS: if pkt_valid and data_in!=INVALID_ADDR, latch dest_addr<=data_in. Then go to LOAD_FIRST_DATA if the selected FIFO is empty, else to WAIT_TILL_EMPTY. Otherwise stay; dest_addr is unchanged.
  - WAIT_TILL_EMPTY: go to LOAD_FIRST_DATA when fifo_empty_<dest_addr>=1, else stay.
  - LOAD_FIRST_DATA: unconditional to LOAD_DATA.
  - LOAD_DATA: fifo_full goes to FIFO_FULL_STATE. Else !pkt_valid goes to LOAD_PARITY. Else stay.
  - FIFO_FULL_STATE: !fifo_full goes to LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL: parity_done goes to DECODE_ADDRESS. Else low_pkt_valid goes to LOAD_PARITY. Else go to LOAD_DATA.
  - LOAD_PARITY: unconditional to CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full goes to FIFO_FULL_STATE, else DECODE_ADDRESS.
- Soft reset: in any state except DECODE_ADDRESS, soft_reset_<dest_addr>=1 forces the next state to DECODE_ADDRESS. This has priority over all other transitions. Soft resets of other ports are ignored. In DECODE_ADDRESS, soft resets are ignored.
- Outputs are Moore, decoded combinationally from the current state (zero-cycle decode, no glitching requirement beyond standard):
  - detect_add=DECODE_ADDRESS
  - lfd_state=LOAD_FIRST_DATA
  - ld_state=LOAD_DATA
  - full_state=FIFO_FULL_STATE
  - laf_state=LOAD_AFTER_FULL
  - rst_int_reg=CHECK_PARITY_ERROR
  - write_enb_reg = LOAD_DATA | LOAD_AFTER_FULL | LOAD_PARITY
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA
- Exactly one state strobe among detect_add/lfd/ld/full/laf/rst_int is high in those six states. None is high in WAIT_TILL_EMPTY or LOAD_PARITY.
- Latency: header accepted to first payload write is 2 clocks (DECODE→LFD→LD). pkt_valid fall to parity check is 2 clocks (LD→LP→CPE).
- Reset asserted mid-packet: immediate return to reset values. No partial strobe persists after the resetn falling edge.
- Illegal or unused state encodings recover to DECODE_ADDRESS on the next clock.

Test Plan:
- Reset, then pkt_valid=1, data_in=2'b01, fifo_empty_1=1 → states DA→LFD→LD on successive clocks; dest_addr=01; write_enb_reg=1 from the 2nd clock; busy=1 only during LFD.
- 5-byte packet to port 0, pkt_valid drops at payload end, fifo_full=0 → LD→LP→CPE→DA; rst_int_reg pulses 1 clock; write_enb_reg high through LP.
- Header data_in=2'b11 with pkt_valid=1 for 4 clocks → stays DA, detect_add=1, dest_addr unchanged, write_enb_reg=0.
- Header to port 2 with fifo_empty_2=0 for 6 clocks → WAIT_TILL_EMPTY, busy=1, write_enb_reg=0; fifo_empty_2 rises → LFD next clock.
- fifo_full=1 in LD for 3 clocks, then 0 with low_pkt_valid=1, parity_done=0 → FFS (busy=1, full_state=1)→LAF→LP→CPE.
- In LD to port 1, pulse soft_reset_0 then soft_reset_1 → soft_reset_0 ignored; soft_reset_1 gives DA next clock. Also, resetn low mid-LD → detect_add=1 and dest_addr=11 asynchronously.
